dft_input_framer: RTL and testbench
===================================

// Module: dft_input_framer
// PURPOSE
// Upstream feeder for top_mixed_radix_dft_0. Takes a raw upstream sample stream (in_sop marks frame
// start, in_dftpts gives frame length) and validates the DFT length against the 34 legal sizes.
// Emits framed sink_* traffic (sop/eop/valid, size code, inverse) honouring sink_ready.
// Enforces a minimum idle gap between frames.
// PARAMETERS
// DW       18  sample width, real and imag each (two's complement)
// MIN_GAP  16  idle cycles forced after each sink_eop transfer before next sink_sop (>=1)
// PORTS
// clk         in   1   clock
// rst_n       in   1   asynchronous reset, active low
// in_valid    in   1   upstream sample valid
// in_ready    out  1   framer accepts sample this cycle (transfer = in_valid & in_ready)
// in_sop      in   1   first sample of upstream frame
// in_real     in   DW  sample real part
// in_imag     in   DW  sample imag part
// in_dftpts   in   12  frame length; sampled only on accepted in_sop sample
// in_inverse  in   1   IDFT select; sampled only on accepted in_sop sample
// sink_valid  out  1   to DFT: sample valid
// sink_ready  in   1   from DFT: ready (transfer = sink_valid & sink_ready)
// sink_sop    out  1   to DFT: first sample of frame
// sink_eop    out  1   to DFT: last sample of frame
// sink_real   out  DW  to DFT: real
// sink_imag   out  DW  to DFT: imag
// size        out  6   size code of current frame, held from sop until next frame's sop
// inverse     out  1   latched in_inverse, held like size
// err_pts     out  1   1-cycle pulse: in_sop accepted with illegal in_dftpts
// err_align   out  1   1-cycle pulse: sample without in_sop in IDLE, or in_sop mid-frame
// BEHAVIOUR
// - Reset: all outputs 0 except in_ready=0; state IDLE, counters 0, size=0, inverse=0.
// - Size map (in_dftpts->size): 12->0,24->1,36->2,48->3,60->4,72->5,96->6,108->7,120->8,144->9,
//   180->10,192->11,216->12,240->13,288->14,300->15,324->16,360->17,384->18,432->19,480->20,
//   540->21,576->22,600->23,648->24,720->25,768->26,864->27,900->28,960->29,972->30,1080->31,
//   1152->32,1200->33; any other value is illegal.
// - Output stage: one register stage. in_ready = (state!=GAP) & (!sink_valid | sink_ready);
//   in DROP/IDLE discards, in_ready=1. An accepted RUN sample appears on sink_* the next cycle.
//   The sink_* bus holds stable while sink_valid & !sink_ready.
// - FSM IDLE: accepted sample with in_sop & legal pts -> latch pts/size/inverse, present sample
//   with sink_sop=1, cnt=1 -> RUN. With pts==12 the 12th sample ends the frame normally.
//   Accepted in_sop with illegal pts -> err_pts pulse, sample dropped -> DROP.
//   Accepted sample with !in_sop -> err_align pulse, dropped, stay IDLE.
// - RUN: each accepted sample forwarded, cnt++.
//   When cnt reaches pts-1 before accept, that sample carries sink_eop=1 -> GAP.
//   An in_sop inside RUN -> err_align pulse; sample forwarded as ordinary data (no restart).
// - DROP: discard all samples until an accepted in_sop; that sample is evaluated exactly as in IDLE.
// - GAP: in_ready=0; gap counter starts on the sink_eop transfer (not on acceptance).
//   After MIN_GAP cycles -> IDLE.
// - size/inverse change only on the cycle sink_sop is first presented.
// - err pulses registered, 1 cycle after the offending accept; both may not assert together.
// - Async reset mid-frame: partial frame abandoned, no eop emitted, restart in IDLE.
// TESTING
// - pts=12, in_valid always high, sink_ready=1 -> 12 sink_valid cycles, sop on 1st, eop on 12th,
//   size=0; next sop no earlier than 16 cycles after eop.
// - pts=1200, inverse=1, sink_ready toggling 1/0 -> exactly 1200 transfers, data order preserved,
//   size=33, inverse=1 held throughout, bus stable during stalls.
// - in_sop with pts=100 then 50 samples then in_sop with pts=96 -> err_pts once,
//   0 sink_valid for the bad frame, then a size=6 frame of 96.
// - 3 samples without in_sop in IDLE -> 3 err_align pulses, no sink traffic.
// - in_sop asserted at sample 5 of a 24-pt frame -> err_align pulse; frame still 24 samples,
//   eop on the 24th.
// - Assert rst_n=0 at sample 300 of a 600-pt frame -> all outputs 0 immediately;
//   after release, next legal frame is clean with sop first.

Source files
------------

// File: rtl/dft_input_framer.sv
// dft_input_framer: validates DFT length on each upstream frame and emits framed sink_* traffic
// through one output register stage, forcing an idle gap after every frame.
module dft_input_framer #(
  parameter int DW      = 18,
  parameter int MIN_GAP = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  input  logic [11:0]   in_dftpts,
  input  logic          in_inverse,
  output logic          sink_valid,
  input  logic          sink_ready,
  output logic          sink_sop,
  output logic          sink_eop,
  output logic [DW-1:0] sink_real,
  output logic [DW-1:0] sink_imag,
  output logic [5:0]    size,
  output logic          inverse,
  output logic          err_pts,
  output logic          err_align
);
  localparam int GW = $clog2(MIN_GAP + 1);
  typedef enum logic [1:0] {IDLE, RUN, DROP, GAP} state_t;
  state_t        state_q;
  logic          alive_q;
  logic [10:0]   pts_q;
  logic [10:0]   cnt_q;
  logic [GW-1:0] gap_q;
  logic [6:0]    lut;
  logic          out_free;
  logic          accept;
  logic          hunting;
  logic          start;
  logic          fwd;
  logic          last;
  // {legal, size code}
  function automatic logic [6:0] size_lut(input logic [11:0] p);
    case (p)
      12'd12:   size_lut = {1'b1, 6'd0};
      12'd24:   size_lut = {1'b1, 6'd1};
      12'd36:   size_lut = {1'b1, 6'd2};
      12'd48:   size_lut = {1'b1, 6'd3};
      12'd60:   size_lut = {1'b1, 6'd4};
      12'd72:   size_lut = {1'b1, 6'd5};
      12'd96:   size_lut = {1'b1, 6'd6};
      12'd108:  size_lut = {1'b1, 6'd7};
      12'd120:  size_lut = {1'b1, 6'd8};
      12'd144:  size_lut = {1'b1, 6'd9};
      12'd180:  size_lut = {1'b1, 6'd10};
      12'd192:  size_lut = {1'b1, 6'd11};
      12'd216:  size_lut = {1'b1, 6'd12};
      12'd240:  size_lut = {1'b1, 6'd13};
      12'd288:  size_lut = {1'b1, 6'd14};
      12'd300:  size_lut = {1'b1, 6'd15};
      12'd324:  size_lut = {1'b1, 6'd16};
      12'd360:  size_lut = {1'b1, 6'd17};
      12'd384:  size_lut = {1'b1, 6'd18};
      12'd432:  size_lut = {1'b1, 6'd19};
      12'd480:  size_lut = {1'b1, 6'd20};
      12'd540:  size_lut = {1'b1, 6'd21};
      12'd576:  size_lut = {1'b1, 6'd22};
      12'd600:  size_lut = {1'b1, 6'd23};
      12'd648:  size_lut = {1'b1, 6'd24};
      12'd720:  size_lut = {1'b1, 6'd25};
      12'd768:  size_lut = {1'b1, 6'd26};
      12'd864:  size_lut = {1'b1, 6'd27};
      12'd900:  size_lut = {1'b1, 6'd28};
      12'd960:  size_lut = {1'b1, 6'd29};
      12'd972:  size_lut = {1'b1, 6'd30};
      12'd1080: size_lut = {1'b1, 6'd31};
      12'd1152: size_lut = {1'b1, 6'd32};
      12'd1200: size_lut = {1'b1, 6'd33};
      default:  size_lut = 7'd0;
    endcase
  endfunction
  assign lut      = size_lut(in_dftpts);
  assign out_free = !sink_valid | sink_ready;
  // alive_q keeps in_ready low while reset is held and until the first clock after release
  assign in_ready = alive_q & (state_q != GAP) & out_free;
  assign accept   = in_valid & in_ready;
  assign hunting  = (state_q == IDLE) | (state_q == DROP);
  assign start    = accept & hunting & in_sop & lut[6];
  assign fwd      = start | (accept & (state_q == RUN));
  assign last     = (state_q == RUN) & (cnt_q == pts_q - 11'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alive_q    <= 1'b0;
      pts_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
      sink_imag  <= '0;
      size       <= '0;
      inverse    <= 1'b0;
      err_pts    <= 1'b0;
      err_align  <= 1'b0;
    end else begin
      alive_q   <= 1'b1;
      err_pts   <= accept & hunting & in_sop & !lut[6];
      err_align <= accept & (((state_q == IDLE) & !in_sop) | ((state_q == RUN) & in_sop));
      if (out_free) begin
        sink_valid <= fwd;
        if (fwd) begin
          sink_sop  <= start;
          sink_eop  <= last;
          sink_real <= in_real;
          sink_imag <= in_imag;
        end
      end
      case (state_q)
        IDLE, DROP: if (accept & in_sop) begin
          if (lut[6]) begin
            pts_q   <= in_dftpts[10:0];
            size    <= lut[5:0];
            inverse <= in_inverse;
            cnt_q   <= 11'd1;
            state_q <= RUN;
          end else state_q <= DROP;
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + 11'd1;
          if (last) begin
            gap_q   <= '0;
            state_q <= GAP;
          end
        end
        // counting begins on the cycle the eop sample actually transfers
        GAP: if (out_free) begin
          if (gap_q == GW'(MIN_GAP - 1)) state_q <= IDLE;
          else gap_q <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dft_input_framer.sv
// tb_dft_input_framer: directed scenario tasks with hand-computed expectations for dft_input_framer.
module tb_dft_input_framer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_inverse = 1'b0, sink_ready = 1'b1;
  logic [17:0] in_real = '0, in_imag = '0;
  logic [11:0] in_dftpts = '0;
  logic        in_ready, sink_valid, sink_sop, sink_eop, inverse, err_pts, err_align;
  logic [17:0] sink_real, sink_imag;
  logic [5:0]  size;
  int vectors = 0, miscompares = 0, rdy_mode = 0, cyc = 0;
  logic [17:0] q_re[$], q_im[$];
  logic        q_sop[$], q_eop[$], q_inv[$];
  logic [5:0]  q_size[$];
  int          q_cyc[$];
  int n_err_pts = 0, n_err_align = 0, n_unstable = 0, n_stalls = 0;
  logic        prev_stall = 1'b0;
  logic [38:0] prev_bus = '0;

  dft_input_framer #(.DW(18), .MIN_GAP(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_real(in_real), .in_imag(in_imag), .in_dftpts(in_dftpts), .in_inverse(in_inverse),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .size(size), .inverse(inverse),
    .err_pts(err_pts), .err_align(err_align)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 sink_ready = (rdy_mode == 1) ? ~sink_ready : 1'b1;
  end

  // transfer recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (sink_valid && sink_ready) begin
      q_re.push_back(sink_real); q_im.push_back(sink_imag);
      q_sop.push_back(sink_sop); q_eop.push_back(sink_eop);
      q_size.push_back(size); q_inv.push_back(inverse); q_cyc.push_back(cyc);
    end
    if (err_pts) n_err_pts++;
    if (err_align) n_err_align++;
    if (prev_stall && {sink_valid, sink_sop, sink_eop, sink_real, sink_imag} != prev_bus) n_unstable++;
    if (sink_valid && !sink_ready) n_stalls++;
    prev_stall = rst_n && sink_valid && !sink_ready;
    prev_bus = {sink_valid, sink_sop, sink_eop, sink_real, sink_imag};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit (required finish)");
    $fatal(1);
  end

  task automatic clr();
    q_re.delete(); q_im.delete(); q_sop.delete(); q_eop.delete();
    q_size.delete(); q_inv.delete(); q_cyc.delete();
    n_err_pts = 0; n_err_align = 0; n_unstable = 0; n_stalls = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sop, input logic [11:0] pts, input logic inv,
                      input logic [17:0] re, input logic [17:0] im);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_sop = sop; in_dftpts = pts; in_inverse = inv; in_real = re; in_imag = im;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_sop = 1'b0;
    if (!ok) begin miscompares++; $display("FAIL push_timeout: in_ready=0 for 100 cycles, required 1"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    vectors++; if (sink_valid !== 1'b0) begin miscompares++; $display("FAIL rst_sink_valid: got %b exp 0", sink_valid); end
    vectors++; if ({sink_sop, sink_eop, sink_real, sink_imag} !== 38'd0) begin miscompares++; $display("FAIL rst_sink_bus: got %h exp 0", {sink_sop, sink_eop, sink_real, sink_imag}); end
    vectors++; if ({size, inverse} !== 7'd0) begin miscompares++; $display("FAIL rst_size_inv: got %h exp 0", {size, inverse}); end
    vectors++; if ({err_pts, err_align} !== 2'd0) begin miscompares++; $display("FAIL rst_err: got %b exp 00", {err_pts, err_align}); end
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_pts12();
    int bad;
    clr(); rdy_mode = 0;
    for (int i = 0; i < 12; i++) push(i == 0, 12'd12, 1'b0, 18'(i + 1), 18'(200 + i));
    for (int i = 0; i < 12; i++) push(i == 0, 12'd12, 1'b0, 18'(50 + i), 18'(300 + i));
    idle(4);
    vectors++; if (q_re.size() !== 24) begin miscompares++; $display("FAIL p12_count: got %0d exp 24", q_re.size()); end
    if (q_re.size() == 24) begin
      bad = 0;
      for (int i = 0; i < 12; i++) begin
        if (q_re[i] !== 18'(i + 1) || q_im[i] !== 18'(200 + i) || q_sop[i] !== (i == 0) || q_eop[i] !== (i == 11) || q_size[i] !== 6'd0) bad++;
        if (q_re[12 + i] !== 18'(50 + i) || q_sop[12 + i] !== (i == 0) || q_eop[12 + i] !== (i == 11)) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL p12_frames: %0d bad samples, exp 0", bad); end
      vectors++; if (q_cyc[12] - q_cyc[11] !== 17) begin miscompares++; $display("FAIL p12_gap: eop->sop %0d cycles, exp 17", q_cyc[12] - q_cyc[11]); end
    end
    vectors++; if (n_err_pts + n_err_align !== 0) begin miscompares++; $display("FAIL p12_err: got %0d exp 0", n_err_pts + n_err_align); end
  endtask

  task automatic test_pts1200();
    int bad, ns, ne;
    clr(); rdy_mode = 1;
    for (int i = 0; i < 1200; i++) push(i == 0, 12'd1200, 1'b1, 18'(i), 18'(i) ^ 18'h2AAAA);
    idle(6); rdy_mode = 0; idle(2);
    vectors++; if (q_re.size() !== 1200) begin miscompares++; $display("FAIL p1200_count: got %0d exp 1200", q_re.size()); end
    if (q_re.size() == 1200) begin
      bad = 0; ns = 0; ne = 0;
      for (int i = 0; i < 1200; i++) begin
        if (q_re[i] !== 18'(i) || q_im[i] !== (18'(i) ^ 18'h2AAAA) || q_size[i] !== 6'd33 || q_inv[i] !== 1'b1) bad++;
        ns += int'(q_sop[i]); ne += int'(q_eop[i]);
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL p1200_data: %0d bad samples, exp 0", bad); end
      vectors++; if ({ns, ne, q_sop[0], q_eop[1199]} !== {32'd1, 32'd1, 1'b1, 1'b1}) begin miscompares++; $display("FAIL p1200_marks: sop=%0d eop=%0d exp 1/1 at ends", ns, ne); end
    end
    vectors++; if (n_unstable !== 0) begin miscompares++; $display("FAIL p1200_stall_stable: %0d changes, exp 0", n_unstable); end
    vectors++; if (n_stalls < 100) begin miscompares++; $display("FAIL p1200_stalls: got %0d exp >=100", n_stalls); end
    vectors++; if ({size, inverse} !== {6'd33, 1'b1}) begin miscompares++; $display("FAIL p1200_held: got %0d/%b exp 33/1", size, inverse); end
  endtask

  task automatic test_bad_pts();
    int bad;
    clr(); rdy_mode = 0;
    push(1'b1, 12'd100, 1'b0, 18'd777, 18'd777);
    for (int i = 0; i < 50; i++) push(1'b0, 12'd100, 1'b0, 18'd777, 18'd777);
    for (int i = 0; i < 96; i++) push(i == 0, 12'd96, 1'b0, 18'(1000 + i), 18'(i));
    idle(4);
    vectors++; if (n_err_pts !== 1) begin miscompares++; $display("FAIL bad_err_pts: got %0d exp 1", n_err_pts); end
    vectors++; if (n_err_align !== 0) begin miscompares++; $display("FAIL bad_err_align: got %0d exp 0", n_err_align); end
    vectors++; if (q_re.size() !== 96) begin miscompares++; $display("FAIL bad_count: got %0d exp 96", q_re.size()); end
    if (q_re.size() == 96) begin
      bad = 0;
      for (int i = 0; i < 96; i++)
        if (q_re[i] !== 18'(1000 + i) || q_sop[i] !== (i == 0) || q_eop[i] !== (i == 95) || q_size[i] !== 6'd6) bad++;
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bad_good_frame: %0d bad samples, exp 0", bad); end
    end
  endtask

  task automatic test_no_sop();
    idle(20); clr();
    for (int i = 0; i < 3; i++) push(1'b0, 12'd12, 1'b0, 18'd5, 18'd5);
    idle(3);
    vectors++; if (n_err_align !== 3) begin miscompares++; $display("FAIL nosop_err_align: got %0d exp 3", n_err_align); end
    vectors++; if (q_re.size() !== 0) begin miscompares++; $display("FAIL nosop_traffic: got %0d exp 0", q_re.size()); end
    vectors++; if (n_err_pts !== 0) begin miscompares++; $display("FAIL nosop_err_pts: got %0d exp 0", n_err_pts); end
  endtask

  task automatic test_mid_sop();
    int bad;
    clr();
    for (int i = 0; i < 24; i++) push(i == 0 || i == 4, 12'd24, 1'b0, 18'(400 + i), 18'(i));
    idle(4);
    vectors++; if (n_err_align !== 1) begin miscompares++; $display("FAIL midsop_err_align: got %0d exp 1", n_err_align); end
    vectors++; if (q_re.size() !== 24) begin miscompares++; $display("FAIL midsop_count: got %0d exp 24", q_re.size()); end
    if (q_re.size() == 24) begin
      bad = 0;
      for (int i = 0; i < 24; i++)
        if (q_re[i] !== 18'(400 + i) || q_sop[i] !== (i == 0) || q_eop[i] !== (i == 23) || q_size[i] !== 6'd1) bad++;
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL midsop_frame: %0d bad samples, exp 0", bad); end
    end
  endtask

  task automatic test_reset_mid();
    int bad, ne;
    idle(20); clr();
    for (int i = 0; i < 299; i++) push(i == 0, 12'd600, 1'b1, 18'(i + 7), 18'(i));
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({in_ready, sink_valid, sink_sop, sink_eop} !== 4'd0) begin miscompares++; $display("FAIL rstmid_ctrl: got %b exp 0000", {in_ready, sink_valid, sink_sop, sink_eop}); end
    vectors++; if ({sink_real, sink_imag, size, inverse} !== 43'd0) begin miscompares++; $display("FAIL rstmid_data: got %h exp 0", {sink_real, sink_imag, size, inverse}); end
    ne = 0;
    foreach (q_eop[i]) ne += int'(q_eop[i]);
    vectors++; if (ne !== 0) begin miscompares++; $display("FAIL rstmid_no_eop: got %0d exp 0", ne); end
    @(negedge clk) rst_n = 1'b1;
    idle(2); clr();
    for (int i = 0; i < 36; i++) push(i == 0, 12'd36, 1'b0, 18'(i + 3), 18'(i));
    idle(4);
    vectors++; if (q_re.size() !== 36) begin miscompares++; $display("FAIL rstmid_count: got %0d exp 36", q_re.size()); end
    if (q_re.size() == 36) begin
      bad = 0;
      for (int i = 0; i < 36; i++)
        if (q_re[i] !== 18'(i + 3) || q_sop[i] !== (i == 0) || q_eop[i] !== (i == 35) || q_size[i] !== 6'd2 || q_inv[i] !== 1'b0) bad++;
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rstmid_frame: %0d bad samples, exp 0", bad); end
    end
    vectors++; if (n_err_pts + n_err_align !== 0) begin miscompares++; $display("FAIL rstmid_err: got %0d exp 0", n_err_pts + n_err_align); end
  endtask

  initial begin
    test_reset();
    test_pts12();
    test_pts1200();
    test_bad_pts();
    test_no_sop();
    test_mid_sop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
